round_robin_arbiter_n: RTL and testbench

ROUND_ROBIN_ARBITER_N -- requirements
Module: round_robin_arbiter_n

---
 rtl/round_robin_arbiter_n.sv | 112 +++++++++++
 tb/tb_round_robin_arbiter_n.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_n.sv
// round_robin_arbiter_n
//   N-way round-robin arbiter with an optional grant lock. While lock is held the current
//   grantee keeps the grant for up to MAX_BURST consecutive cycles, after which rotation is
//   forced. Grants are combinational from requests, lock and the registered state.
//
// Parameters
//   N          number of requesters (2..32)
//   MAX_BURST  max consecutive locked grants to one requester (>= 1)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset; also forces grants to zero
//   requests     per-requester request, bit i = requester i
//   lock         asks that the current grantee keep the grant on following cycles
//   grants       one-hot grant vector, zero when nothing requests or in reset
//   grant_valid  (ROUND_ROBIN_ARBITER_N_GRANT_ID_EN only) equals |grants
//   grant_id     (ROUND_ROBIN_ARBITER_N_GRANT_ID_EN only) binary index of the granted bit
//
// Optional feature macro: ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
module round_robin_arbiter_n #(
   parameter int unsigned N         = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         requests,
   input  logic                 lock,
   output logic [N-1:0]         grants
`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
   ,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id
`endif
);

   localparam int unsigned LW = $clog2(N);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);
   localparam logic [LW-1:0] LastRst  = LW'(N - 1);

   if (N < 2 || N > 32) begin : gen_bad_n
      $error("round_robin_arbiter_n: N must be in 2..32");
   end
   if (MAX_BURST < 1) begin : gen_bad_burst
      $error("round_robin_arbiter_n: MAX_BURST must be >= 1");
   end

   logic [LW-1:0] last;
   logic          held;
   logic [BW-1:0] burst_cnt;

   logic          any_req;
   logic          grant_en;
   logic          lock_cond;
   logic          rr_found;
   logic [LW-1:0] rr_idx;
   logic [LW-1:0] cand;
   logic [LW-1:0] grant_idx;

   assign any_req  = |requests;
   assign grant_en = any_req && !rst;

   // Once burst_cnt reaches MAX_BURST this goes false, so the search below takes over and
   // naturally re-grants last only when nobody else is requesting.
   assign lock_cond = held && lock && requests[last] && (burst_cnt < BurstMax);

   // Search upward from last+1 with wrap; last itself is the final candidate (k = N).
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = last;
      cand     = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = LW'((32'(last) + k) % N);
         if (!rr_found && requests[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   assign grant_idx = lock_cond ? last : rr_idx;

   always_comb begin
      grants = '0;
      if (grant_en) begin
         grants[grant_idx] = 1'b1;
      end
   end

`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
   assign grant_valid = grant_en;
   assign grant_id    = grant_en ? grant_idx : '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= LastRst;
         held      <= 1'b0;
         burst_cnt <= '0;
      end else if (any_req) begin
         last      <= grant_idx;
         held      <= lock;
         burst_cnt <= lock_cond ? burst_cnt + BW'(1) : BW'(1);
      end else begin
         // Idle cycle: lock is ignored and any burst is abandoned; priority pointer is kept.
         held      <= 1'b0;
         burst_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Self-checking bench for round_robin_arbiter_n. Three instances cover N=4/MAX_BURST=2,
// N=2/MAX_BURST=4 and N=4/MAX_BURST=1 (pure round-robin). A behavioural model tracks each
// instance; directed tests compare against constant tables, the random test against the model.
module tb_round_robin_arbiter_n;

   logic       clk = 1'b0;
   logic       rst;
   logic       lock;
   logic [3:0] req_a, req_c;
   logic [1:0] req_b;
   logic [3:0] gnt_a, gnt_c;
   logic [1:0] gnt_b;
`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
   logic       gv_a, gv_b, gv_c;
   logic [1:0] gid_a, gid_c;
   logic [0:0] gid_b;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   round_robin_arbiter_n #(.N(4), .MAX_BURST(2)) dut_a (
      .clk(clk), .rst(rst), .requests(req_a), .lock(lock), .grants(gnt_a)
`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
      , .grant_valid(gv_a), .grant_id(gid_a)
`endif
   );

   round_robin_arbiter_n #(.N(2), .MAX_BURST(4)) dut_b (
      .clk(clk), .rst(rst), .requests(req_b), .lock(lock), .grants(gnt_b)
`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
      , .grant_valid(gv_b), .grant_id(gid_b)
`endif
   );

   round_robin_arbiter_n #(.N(4), .MAX_BURST(1)) dut_c (
      .clk(clk), .rst(rst), .requests(req_c), .lock(lock), .grants(gnt_c)
`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
      , .grant_valid(gv_c), .grant_id(gid_c)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct {
      int last;
      bit held;
      int cnt;
   } mstate_t;

   mstate_t st_a, st_b, st_c;
   logic [31:0] exp_a, exp_b, exp_c;
   int          eid_a;

   // Index granted this cycle, or -1 for none.
   function automatic int mgrant(input mstate_t s, input int n, input int mb,
                                 input logic [31:0] req, input bit lk, input bit r);
      if (r || req == 0) return -1;
      if (s.held && lk && req[s.last] && s.cnt < mb) return s.last;
      for (int k = 1; k <= n; k++) begin
         if (req[(s.last + k) % n]) return (s.last + k) % n;
      end
      return -1;
   endfunction

   function automatic mstate_t mnext(input mstate_t s, input int n, input int mb,
                                     input logic [31:0] req, input bit lk, input bit r);
      mstate_t ns;
      int      g;
      bit      locked;
      ns = s;
      if (r) begin
         ns.last = n - 1;
         ns.held = 0;
         ns.cnt  = 0;
      end else begin
         g = mgrant(s, n, mb, req, lk, r);
         if (g < 0) begin
            ns.held = 0;
            ns.cnt  = 0;
         end else begin
            locked  = s.held && lk && req[s.last] && s.cnt < mb;
            ns.cnt  = locked ? s.cnt + 1 : 1;
            ns.held = lk;
            ns.last = g;
         end
      end
      return ns;
   endfunction

   function automatic logic [31:0] onehot(input int g);
      logic [31:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   // Drive one cycle of inputs at the falling edge, compute expectations, advance models.
   // Outputs are stable and checkable on return, before the next rising edge.
   task automatic step(input logic [3:0] ra, input logic [1:0] rb, input logic [3:0] rc,
                       input bit lk, input bit r);
      int g;
      @(negedge clk);
      req_a = ra;
      req_b = rb;
      req_c = rc;
      lock  = lk;
      rst   = r;
      #1;
      g     = mgrant(st_a, 4, 2, 32'(ra), lk, r);
      exp_a = onehot(g);
      eid_a = (g < 0) ? 0 : g;
      exp_b = onehot(mgrant(st_b, 2, 4, 32'(rb), lk, r));
      exp_c = onehot(mgrant(st_c, 4, 1, 32'(rc), lk, r));
      st_a  = mnext(st_a, 4, 2, 32'(ra), lk, r);
      st_b  = mnext(st_b, 2, 4, 32'(rb), lk, r);
      st_c  = mnext(st_c, 4, 1, 32'(rc), lk, r);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step(4'b1111, 2'b11, 4'b1111, 1'b1, 1'b1);
      n_checks++;
      if ({gnt_a, gnt_b, gnt_c} !== 10'b0)
         $display("FAIL reset_grants_zero: got %b/%b/%b want 0", gnt_a, gnt_b, gnt_c);
      else n_pass++;
   endtask

   task automatic test_rotation();
      logic [3:0] want [5];
      want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      test_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0);
         n_checks++;
         if (gnt_a !== want[i])
            $display("FAIL rotation[%0d]: got %b want %b", i, gnt_a, want[i]);
         else n_pass++;
      end
   endtask

   task automatic test_n2();
      logic [1:0] rq   [10];
      logic [1:0] want [10];
      rq   = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
      want = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
      test_reset();
      for (int i = 0; i < 10; i++) begin
         step(4'b0000, rq[i], 4'b0000, 1'b0, 1'b0);
         n_checks++;
         if (gnt_b !== want[i])
            $display("FAIL n2_seq[%0d]: got %b want %b", i, gnt_b, want[i]);
         else n_pass++;
      end
   endtask

   task automatic test_lock_burst();
      logic [3:0] want [5];
      want = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000};
      test_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b1011, 2'b00, 4'b1011, 1'b1, 1'b0);
         n_checks++;
         if (gnt_a !== want[i])
            $display("FAIL lock_burst[%0d]: got %b want %b", i, gnt_a, want[i]);
         else n_pass++;
      end
      // Burst limit with a single requester: re-granted indefinitely.
      test_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b0100, 2'b00, 4'b0100, 1'b1, 1'b0);
         n_checks++;
         if (gnt_a !== 4'b0100)
            $display("FAIL lone_holder[%0d]: got %b want 0100", i, gnt_a);
         else n_pass++;
      end
   endtask

   task automatic test_holder_drop();
      test_reset();
      step(4'b0011, 2'b00, 4'b0000, 1'b1, 1'b0);
      n_checks++;
      if (gnt_a !== 4'b0001) $display("FAIL drop_first: got %b want 0001", gnt_a);
      else n_pass++;
      step(4'b0010, 2'b00, 4'b0000, 1'b1, 1'b0);
      n_checks++;
      if (gnt_a !== 4'b0010) $display("FAIL drop_move: got %b want 0010", gnt_a);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      test_reset();
      step(4'b0100, 2'b00, 4'b0000, 1'b1, 1'b0);
      n_checks++;
      if (gnt_a !== 4'b0100) $display("FAIL mid_pre: got %b want 0100", gnt_a);
      else n_pass++;
      step(4'b0100, 2'b00, 4'b0000, 1'b1, 1'b0);
      step(4'b1111, 2'b11, 4'b1111, 1'b1, 1'b1);
      n_checks++;
      if (gnt_a !== 4'b0000) $display("FAIL mid_in_rst: got %b want 0000", gnt_a);
      else n_pass++;
      step(4'b1111, 2'b00, 4'b0000, 1'b1, 1'b0);
      n_checks++;
      if (gnt_a !== 4'b0001) $display("FAIL mid_after: got %b want 0001", gnt_a);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] ra, rc;
      logic [1:0] rb;
      bit         lk, r;
      test_reset();
      for (int i = 0; i < 400; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 2'($urandom_range(0, 3));
         rc = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) ra = 4'b0000;
         lk = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 40) == 0);
         step(ra, rb, rc, lk, r);
         n_checks++;
         if (gnt_a !== exp_a[3:0])
            $display("FAIL rand_a[%0d]: got %b want %b", i, gnt_a, exp_a[3:0]);
         else n_pass++;
         n_checks++;
         if (gnt_b !== exp_b[1:0])
            $display("FAIL rand_b[%0d]: got %b want %b", i, gnt_b, exp_b[1:0]);
         else n_pass++;
         n_checks++;
         if (gnt_c !== exp_c[3:0])
            $display("FAIL rand_c[%0d]: got %b want %b", i, gnt_c, exp_c[3:0]);
         else n_pass++;
`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
         n_checks++;
         if ({gv_a, gid_a} !== {|exp_a[3:0], 2'(eid_a)})
            $display("FAIL rand_id[%0d]: got %b/%0d want %b/%0d", i, gv_a, gid_a,
                     |exp_a[3:0], eid_a);
         else n_pass++;
`endif
      end
   endtask

`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
   task automatic test_grant_id();
      test_reset();
      step(4'b0100, 2'b00, 4'b0000, 1'b0, 1'b0);
      n_checks++;
      if ({gv_a, gid_a} !== 3'b1_10)
         $display("FAIL grant_id_set: got %b/%0d want 1/2", gv_a, gid_a);
      else n_pass++;
      step(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
      n_checks++;
      if ({gv_a, gid_a} !== 3'b0_00)
         $display("FAIL grant_id_idle: got %b/%0d want 0/0", gv_a, gid_a);
      else n_pass++;
   endtask
`endif

   initial begin
      rst   = 1'b1;
      lock  = 1'b0;
      req_a = '0;
      req_b = '0;
      req_c = '0;
      st_a  = '{last: 3, held: 0, cnt: 0};
      st_b  = '{last: 1, held: 0, cnt: 0};
      st_c  = '{last: 3, held: 0, cnt: 0};
      test_reset();
      test_rotation();
      test_n2();
      test_lock_burst();
      test_holder_drop();
      test_reset_mid();
`ifdef ROUND_ROBIN_ARBITER_N_GRANT_ID_EN
      test_grant_id();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
